// File: rtl/ntm_simd_modular_multiplier.sv
// SIMD modular multiplier: per lane DATA_OUT = (A * B) mod X.
// Each lane first reduces B modulo X bit-serially (MSB first). It then runs a
// shift-and-add multiply of A by that residue, keeping the accumulator reduced
// on every step. Both phases take DATA_SIZE cycles, so START to READY is
// 2*DATA_SIZE+1 clock edges.
module ntm_simd_modular_multiplier #(
   parameter int DATA_SIZE = 64,
   parameter int LANES     = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       START,
   input  logic [LANES-1:0]           ENABLE,
   input  logic [LANES*DATA_SIZE-1:0] DATA_A_IN,
   input  logic [LANES*DATA_SIZE-1:0] DATA_B_IN,
   input  logic [LANES*DATA_SIZE-1:0] DATA_X_IN,
   output logic                       BUSY,
   output logic                       READY,
   output logic [LANES-1:0]           ERROR,
   output logic [LANES*DATA_SIZE-1:0] DATA_OUT
);

   localparam int W  = DATA_SIZE + 1;
   localparam int CW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(DATA_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE,
      REDUCE,
      MULTIPLY,
      ENDER
   } state_t;

   state_t                     state_q;
   logic [CW-1:0]              cnt_q;
   logic [LANES*DATA_SIZE-1:0] a_q;
   logic [LANES*DATA_SIZE-1:0] b_q;
   logic [LANES*DATA_SIZE-1:0] x_q;
   logic [LANES-1:0]           en_q;
   logic [W-1:0]               r_q   [LANES];
   logic [W-1:0]               acc_q [LANES];

   logic [DATA_SIZE-1:0]       a_lane  [LANES];
   logic [DATA_SIZE-1:0]       b_lane  [LANES];
   logic [W-1:0]               x_w     [LANES];
   logic [W-1:0]               red_sum [LANES];
   logic [W-1:0]               red_nxt [LANES];
   logic [W-1:0]               dbl     [LANES];
   logic [W-1:0]               dbl_m   [LANES];
   logic [W-1:0]               add     [LANES];
   logic [W-1:0]               add_m   [LANES];
   logic [W-1:0]               mul_nxt [LANES];

   // Per-lane next residue (reduce step) and next accumulator (multiply step).
   // r and acc stay below X in a valid lane, so the low DATA_SIZE bits are
   // enough to form 2r+b and 2*acc. One conditional subtract is then enough
   // to restore the invariant.
   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         a_lane[i]  = a_q[i*DATA_SIZE +: DATA_SIZE];
         b_lane[i]  = b_q[i*DATA_SIZE +: DATA_SIZE];
         x_w[i]     = {1'b0, x_q[i*DATA_SIZE +: DATA_SIZE]};
         red_sum[i] = {r_q[i][DATA_SIZE-1:0], b_lane[i][cnt_q]};
         red_nxt[i] = (red_sum[i] >= x_w[i]) ? red_sum[i] - x_w[i] : red_sum[i];
         dbl[i]     = {acc_q[i][DATA_SIZE-1:0], 1'b0};
         dbl_m[i]   = (dbl[i] >= x_w[i]) ? dbl[i] - x_w[i] : dbl[i];
         add[i]     = dbl_m[i] + r_q[i];
         add_m[i]   = (add[i] >= x_w[i]) ? add[i] - x_w[i] : add[i];
         mul_nxt[i] = a_lane[i][cnt_q] ? add_m[i] : dbl_m[i];
      end
   end

   // Control FSM, operand latches, per-lane datapath registers and outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         x_q      <= '0;
         en_q     <= '0;
         BUSY     <= 1'b0;
         READY    <= 1'b0;
         ERROR    <= '0;
         DATA_OUT <= '0;
         for (int unsigned i = 0; i < LANES; i++) begin
            r_q[i]   <= '0;
            acc_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               READY <= 1'b0;
               if (START) begin
                  a_q   <= DATA_A_IN;
                  b_q   <= DATA_B_IN;
                  x_q   <= DATA_X_IN;
                  en_q  <= ENABLE;
                  cnt_q <= CNT_TOP;
                  for (int unsigned i = 0; i < LANES; i++) begin
                     r_q[i]   <= '0;
                     acc_q[i] <= '0;
                  end
                  BUSY    <= 1'b1;
                  state_q <= REDUCE;
               end
            end
            REDUCE: begin
               for (int unsigned i = 0; i < LANES; i++) begin
                  r_q[i] <= red_nxt[i];
               end
               if (cnt_q == '0) begin
                  cnt_q   <= CNT_TOP;
                  state_q <= MULTIPLY;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            MULTIPLY: begin
               for (int unsigned i = 0; i < LANES; i++) begin
                  acc_q[i] <= mul_nxt[i];
               end
               if (cnt_q == '0) begin
                  state_q <= ENDER;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            ENDER: begin
               for (int unsigned i = 0; i < LANES; i++) begin
                  if (!en_q[i]) begin
                     DATA_OUT[i*DATA_SIZE +: DATA_SIZE] <= '0;
                     ERROR[i]                           <= 1'b0;
                  end else if (x_q[i*DATA_SIZE +: DATA_SIZE] == '0) begin
                     DATA_OUT[i*DATA_SIZE +: DATA_SIZE] <= '0;
                     ERROR[i]                           <= 1'b1;
                  end else begin
                     DATA_OUT[i*DATA_SIZE +: DATA_SIZE] <= acc_q[i][DATA_SIZE-1:0];
                     ERROR[i]                           <= 1'b0;
                  end
               end
               READY   <= 1'b1;
               BUSY    <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ntm_simd_modular_multiplier.sv
// Directed bench for ntm_simd_modular_multiplier with DATA_SIZE=8, LANES=2.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_ntm_simd_modular_multiplier;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic [1:0]  ENABLE;
   logic [15:0] DATA_A_IN;
   logic [15:0] DATA_B_IN;
   logic [15:0] DATA_X_IN;
   logic        BUSY;
   logic        READY;
   logic [1:0]  ERROR;
   logic [15:0] DATA_OUT;

   int passed = 0;
   int total  = 0;

   ntm_simd_modular_multiplier #(
      .DATA_SIZE (8),
      .LANES     (2)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .START     (START),
      .ENABLE    (ENABLE),
      .DATA_A_IN (DATA_A_IN),
      .DATA_B_IN (DATA_B_IN),
      .DATA_X_IN (DATA_X_IN),
      .BUSY      (BUSY),
      .READY     (READY),
      .ERROR     (ERROR),
      .DATA_OUT  (DATA_OUT)
   );

   // 10 ns clock
   always #5 CLK = ~CLK;

   task automatic drive(input logic [7:0] a0, b0, x0, a1, b1, x1, input logic [1:0] en);
      DATA_A_IN = {a1, a0};
      DATA_B_IN = {b1, b0};
      DATA_X_IN = {x1, x0};
      ENABLE    = en;
   endtask

   // START is sampled at the next rising edge ("edge 0"). On return we are at the falling edge after it.
   task automatic launch(input logic [7:0] a0, b0, x0, a1, b1, x1, input logic [1:0] en);
      @(negedge CLK);
      drive(a0, b0, x0, a1, b1, x1, en);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   // Counts falling edges until READY is seen, up to a bound. Returns -1 if READY never rises.
   task automatic wait_ready(output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge CLK);
         if (READY) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      START = 1'b0;
      drive(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 2'b00);
      repeat (3) @(negedge CLK);
      total++;
      if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b expected 0", BUSY); else passed++;
      total++;
      if (READY !== 1'b0) $display("FAIL reset_ready: got %b expected 0", READY); else passed++;
      total++;
      if (ERROR !== 2'b00) $display("FAIL reset_error: got %b expected 00", ERROR); else passed++;
      total++;
      if (DATA_OUT !== 16'h0000) $display("FAIL reset_data: got %h expected 0000", DATA_OUT); else passed++;
      RST = 1'b0;
   endtask

   task automatic test_vectors();
      logic [7:0]  va0 [7] = '{8'd7,   8'd3,   8'd2, 8'd5, 8'd254, 8'd0,  8'd6};
      logic [7:0]  vb0 [7] = '{8'd5,   8'd200, 8'd2, 8'd6, 8'd254, 8'd77, 8'd7};
      logic [7:0]  vx0 [7] = '{8'd11,  8'd7,   8'd3, 8'd0, 8'd255, 8'd9,  8'd10};
      logic [7:0]  va1 [7] = '{8'd255, 8'd9,   8'd2, 8'd4, 8'd100, 8'd13, 8'd5};
      logic [7:0]  vb1 [7] = '{8'd255, 8'd9,   8'd3, 8'd4, 8'd250, 8'd11, 8'd5};
      logic [7:0]  vx1 [7] = '{8'd251, 8'd1,   8'd4, 8'd5, 8'd13,  8'd255, 8'd0};
      logic [1:0]  ven [7] = '{2'b11,  2'b11,  2'b10, 2'b11, 2'b11, 2'b11, 2'b01};
      logic [15:0] eout[7] = '{{8'd16, 8'd2}, {8'd0, 8'd5}, {8'd2, 8'd0}, {8'd1, 8'd0},
                               {8'd1, 8'd1}, {8'd143, 8'd0}, {8'd0, 8'd2}};
      logic [1:0]  eerr[7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
      int lat;
      for (int v = 0; v < 7; v++) begin
         launch(va0[v], vb0[v], vx0[v], va1[v], vb1[v], vx1[v], ven[v]);
         total++;
         if (BUSY !== 1'b1) $display("FAIL vec%0d_busy: got %b expected 1", v, BUSY); else passed++;
         wait_ready(lat);
         total++;
         if (lat !== 17) $display("FAIL vec%0d_latency: got %0d expected 17", v, lat); else passed++;
         total++;
         if (DATA_OUT !== eout[v]) $display("FAIL vec%0d_data: got %h expected %h", v, DATA_OUT, eout[v]); else passed++;
         total++;
         if (ERROR !== eerr[v]) $display("FAIL vec%0d_error: got %b expected %b", v, ERROR, eerr[v]); else passed++;
         @(negedge CLK);
         total++;
         if (READY !== 1'b0 || DATA_OUT !== eout[v])
            $display("FAIL vec%0d_pulse_hold: got ready=%b data=%h expected ready=0 data=%h", v, READY, DATA_OUT, eout[v]);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      launch(8'd7, 8'd5, 8'd11, 8'd255, 8'd255, 8'd251, 2'b11);
      repeat (4) @(negedge CLK);
      // START while busy is sampled at edge 5. Operand changes must also be ignored.
      drive(8'd3, 8'd200, 8'd7, 8'd9, 8'd9, 8'd1, 2'b01);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_ready(lat);
      total++;
      if (lat !== 12) $display("FAIL b2b_first_latency: got %0d expected 12", lat); else passed++;
      total++;
      if (DATA_OUT !== {8'd16, 8'd2}) $display("FAIL b2b_first_data: got %h expected 1002", DATA_OUT); else passed++;
      // START held during the READY cycle is sampled at edge 18.
      drive(8'd254, 8'd254, 8'd255, 8'd100, 8'd250, 8'd13, 2'b11);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      total++;
      if (BUSY !== 1'b1) $display("FAIL b2b_second_busy: got %b expected 1", BUSY); else passed++;
      wait_ready(lat);
      total++;
      if (lat !== 17) $display("FAIL b2b_second_latency: got %0d expected 17", lat); else passed++;
      total++;
      if (DATA_OUT !== {8'd1, 8'd1}) $display("FAIL b2b_second_data: got %h expected 0101", DATA_OUT); else passed++;
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen;
      launch(8'd0, 8'd77, 8'd9, 8'd13, 8'd11, 8'd255, 2'b11);
      repeat (8) @(negedge CLK);
      RST = 1'b1;
      #1;
      total++;
      if (BUSY !== 1'b0 || READY !== 1'b0) $display("FAIL midrst_ctrl: got busy=%b ready=%b expected 0 0", BUSY, READY); else passed++;
      total++;
      if (DATA_OUT !== 16'h0000) $display("FAIL midrst_data: got %h expected 0000", DATA_OUT); else passed++;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      seen = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge CLK);
         if (READY) seen++;
      end
      total++;
      if (seen !== 0) $display("FAIL midrst_no_ready: got %0d pulses expected 0", seen); else passed++;
      launch(8'd0, 8'd77, 8'd9, 8'd13, 8'd11, 8'd255, 2'b11);
      wait_ready(lat);
      total++;
      if (lat !== 17) $display("FAIL midrst_rerun_latency: got %0d expected 17", lat); else passed++;
      total++;
      if (DATA_OUT !== {8'd143, 8'd0}) $display("FAIL midrst_rerun_data: got %h expected 8f00", DATA_OUT); else passed++;
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ntm_simd_modular_multiplier.md
NTM_SIMD_MODULAR_MULTIPLIER -- requirements
Module: ntm_simd_modular_multiplier

Interface
REQ-001 Parameter DATA_SIZE, default 64, operand/result width per lane (>=2).
REQ-002 Parameter LANES, default 4, number of independent SIMD lanes (>=1).
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 START  input  1  operation request, sampled only in IDLE.
REQ-006 ENABLE  input  LANES  per-lane enable mask, latched with START.
REQ-007 DATA_A_IN  input  LANES*DATA_SIZE  packed multiplicands; lane i at bits [i*DATA_SIZE +: DATA_SIZE].
REQ-008 DATA_B_IN  input  LANES*DATA_SIZE  packed multipliers, same packing.
REQ-009 DATA_X_IN  input  LANES*DATA_SIZE  packed moduli, same packing.
REQ-010 BUSY  output  1  high while an operation is in progress.
REQ-011 READY  output  1  one-cycle completion pulse.
REQ-012 ERROR  output  LANES  per-lane modulus-zero flag, valid with READY.
REQ-013 DATA_OUT  output  LANES*DATA_SIZE  packed results, lane i = (A_i*B_i) mod X_i.

Function
REQ-014 FSM states SHALL be IDLE, REDUCE, MULTIPLY, ENDER; default/illegal encoding -> IDLE.
REQ-015 IDLE: READY<=0; on START=1 latch A, B, X, ENABLE for all lanes, bit counter <= DATA_SIZE-1, residue r<=0, accumulator acc<=0, BUSY<=1, go REDUCE.
REQ-016 Inputs other than START SHALL be ignored after the latch; changes mid-operation do not affect results.
REQ-017 REDUCE (DATA_SIZE cycles, MSB first): per lane r <= (2r + B[cnt]) minus X if that value >= X; at cnt=0 reset cnt to DATA_SIZE-1, go MULTIPLY; r then equals B mod X.
REQ-018 MULTIPLY (DATA_SIZE cycles, MSB first): per lane t=2*acc, t-=X if t>=X; if A[cnt]=1 then t+=r, t-=X if t>=X; acc<=t; at cnt=0 go ENDER.
REQ-019 Internal r, acc, t SHALL be DATA_SIZE+1 bits wide so 2*acc and acc+r never overflow.
REQ-020 ENDER: per enabled lane DATA_OUT lane <= acc[DATA_SIZE-1:0]; READY<=1, BUSY<=0, go IDLE.
REQ-021 Latency: with START sampled at edge 0, DATA_OUT/READY SHALL update at edge 2*DATA_SIZE+1; READY high exactly one cycle.
REQ-022 Lane with X=0: DATA_OUT lane <= 0, ERROR bit <= 1; other lanes unaffected.
REQ-023 Disabled lane (ENABLE bit 0): DATA_OUT lane <= 0, ERROR bit <= 0.
REQ-024 X=1: result 0, no error; B>=X and A>=X SHALL be handled (full-range operands).
REQ-025 START while BUSY=1 SHALL be ignored; START in the READY-high cycle (IDLE) SHALL be accepted.
REQ-026 DATA_OUT and ERROR SHALL hold their values until the next ENDER.

Reset
REQ-027 RST=1 SHALL immediately force state IDLE, BUSY=0, READY=0, ERROR=0, DATA_OUT=0, counter/r/acc=0.
REQ-028 RST mid-operation SHALL abort with no READY pulse; next START after release runs normally.

Verification (DATA_SIZE=8, LANES=2)
REQ-029 Lane0 A=7,B=5,X=11; lane1 A=255,B=255,X=251; ENABLE=11 -> READY at edge 17, lane0=2, lane1=16, ERROR=00.
REQ-030 Lane0 A=3,B=200,X=7; lane1 A=9,B=9,X=1 -> lane0=5, lane1=0, ERROR=00.
REQ-031 Lane0 X=0 (A=5,B=6); lane1 A=4,B=4,X=5, ENABLE=11 -> lane0=0, ERROR=01, lane1=1.
REQ-032 ENABLE=10, lane0 A=2,B=2,X=3; lane1 A=2,B=3,X=4 -> lane0=0, lane1=2, ERROR=00.
REQ-033 START pulsed again at edge 5 with new operands -> ignored, results from first operands; START held at edge 18 -> second operation accepted, READY at edge 35.
REQ-034 RST asserted at edge 9 of an operation -> BUSY=0, no READY, DATA_OUT=0; rerun after release gives correct result.
